// File: rtl/pipe_mac.sv
// pipe_mac: pipelined signed/unsigned multiply-accumulate with sticky overflow flag.
// Optional build macro PIPE_MAC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module pipe_mac #(
  parameter int AW   = 27,
  parameter int BW   = 18,
  parameter int ACCW = 48,
  parameter int PIPE = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            in_valid,
  input  logic            is_signed,
  input  logic            acc_mode,
  input  logic            clr,
  input  logic [AW-1:0]   ain,
  input  logic [BW-1:0]   bin,
  output logic            out_valid,
  output logic [ACCW-1:0] acc,
  output logic            ovf
);

  localparam int MW = AW + BW;

  logic [AW-1:0]          r_a_p0;
  logic [BW-1:0]          r_b_p0;
  logic                   r_vld_p  [PIPE];
  logic                   r_sgn_p  [PIPE];
  logic                   r_mode_p [PIPE];
  logic                   r_clr_p  [PIPE];

  logic signed [MW-1:0]   w_a_ext;
  logic signed [MW-1:0]   w_b_ext;
  logic signed [MW-1:0]   w_prod_mw;
  logic [ACCW-1:0]        w_prod_p0;
  logic [ACCW-1:0]        w_prod_acc;

  logic                   w_vld_a;
  logic                   w_sgn_a;
  logic                   w_mode_a;
  logic                   w_clr_a;
  logic [ACCW:0]          w_sum;
  logic                   w_accum;
  logic                   w_ovf_now;
  logic [ACCW-1:0]        w_acc_nxt;
  logic                   w_ovf_nxt;

  logic                   r_out_valid;
  logic [ACCW-1:0]        r_acc;
  logic                   r_ovf;

`ifdef PIPE_MAC_SAT_EN
  // Signed overflow only happens when both addends share a sign, so the old acc sign picks the rail.
  function automatic logic [ACCW-1:0] sat_limit(input logic sgn, input logic neg);
    logic [ACCW-1:0] lim;
    if (!sgn)
      lim = '1;
    else if (neg)
      lim = {1'b1, {(ACCW-1){1'b0}}};
    else
      lim = {1'b0, {(ACCW-1){1'b1}}};
    return lim;
  endfunction
`endif

  // ---- stage p0: operand capture; control shifts alongside the product pipe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_p0 <= '0;
      r_b_p0 <= '0;
      for (int i = 0; i < PIPE; i++) begin
        r_vld_p[i]  <= 1'b0;
        r_sgn_p[i]  <= 1'b0;
        r_mode_p[i] <= 1'b0;
        r_clr_p[i]  <= 1'b0;
      end
    end else if (ce) begin
      r_a_p0      <= ain;
      r_b_p0      <= bin;
      r_vld_p[0]  <= in_valid;
      r_sgn_p[0]  <= is_signed;
      r_mode_p[0] <= acc_mode;
      r_clr_p[0]  <= clr;
      for (int i = 1; i < PIPE; i++) begin
        r_vld_p[i]  <= r_vld_p[i-1];
        r_sgn_p[i]  <= r_sgn_p[i-1];
        r_mode_p[i] <= r_mode_p[i-1];
        r_clr_p[i]  <= r_clr_p[i-1];
      end
    end
  end

  // ---- multiply: both operands widened to MW so one signed multiplier covers both modes ----
  always_comb begin
    if (r_sgn_p[0]) begin
      w_a_ext = MW'(signed'(r_a_p0));
      w_b_ext = MW'(signed'(r_b_p0));
    end else begin
      w_a_ext = MW'(r_a_p0);
      w_b_ext = MW'(r_b_p0);
    end
    w_prod_mw = w_a_ext * w_b_ext;
    if (r_sgn_p[0])
      w_prod_p0 = ACCW'(w_prod_mw);
    else
      w_prod_p0 = ACCW'($unsigned(w_prod_mw));
  end

  // ---- stages p1..p(PIPE-1): product registers ----
  generate
    if (PIPE > 1) begin : g_prod_pipe
      logic [ACCW-1:0] r_prod_p [PIPE-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE-1; i++) r_prod_p[i] <= '0;
        end else if (ce) begin
          r_prod_p[0] <= w_prod_p0;
          for (int i = 1; i < PIPE-1; i++) r_prod_p[i] <= r_prod_p[i-1];
        end
      end

      assign w_prod_acc = r_prod_p[PIPE-2];
    end else begin : g_prod_comb
      assign w_prod_acc = w_prod_p0;
    end
  endgenerate

  assign w_vld_a  = r_vld_p[PIPE-1];
  assign w_sgn_a  = r_sgn_p[PIPE-1];
  assign w_mode_a = r_mode_p[PIPE-1];
  assign w_clr_a  = r_clr_p[PIPE-1];

  // ---- accumulator stage ----
  always_comb begin
    w_sum   = {1'b0, r_acc} + {1'b0, w_prod_acc};
    w_accum = w_mode_a & ~w_clr_a;
    if (w_sgn_a)
      w_ovf_now = w_accum & (r_acc[ACCW-1] == w_prod_acc[ACCW-1]) &
                  (w_sum[ACCW-1] != r_acc[ACCW-1]);
    else
      w_ovf_now = w_accum & w_sum[ACCW];

    if (!w_accum)
      w_acc_nxt = w_prod_acc;
`ifdef PIPE_MAC_SAT_EN
    else if (w_ovf_now)
      w_acc_nxt = sat_limit(w_sgn_a, r_acc[ACCW-1]);
`endif
    else
      w_acc_nxt = w_sum[ACCW-1:0];

    // clr wipes the sticky flag before this slot is judged
    w_ovf_nxt = (r_ovf & ~w_clr_a) | w_ovf_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
    end else if (ce) begin
      r_out_valid <= w_vld_a;
      if (w_vld_a) begin
        r_acc <= w_acc_nxt;
        r_ovf <= w_ovf_nxt;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign acc       = r_acc;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_mac.sv
// Self-checking bench for pipe_mac: arithmetic reference model plus directed literal expectations.
module tb_pipe_mac;
  localparam int AW   = 27;
  localparam int BW   = 18;
  localparam int ACCW = 48;
  localparam int PIPE = 3;
`ifdef PIPE_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ce = 1'b0;
  logic            in_valid = 1'b0;
  logic            is_signed = 1'b0;
  logic            acc_mode = 1'b0;
  logic            clr = 1'b0;
  logic [AW-1:0]   ain = '0;
  logic [BW-1:0]   bin = '0;
  logic            out_valid;
  logic [ACCW-1:0] acc;
  logic            ovf;

  pipe_mac #(.AW(AW), .BW(BW), .ACCW(ACCW), .PIPE(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .is_signed(is_signed),
    .acc_mode(acc_mode), .clr(clr), .ain(ain), .bin(bin),
    .out_valid(out_valid), .acc(acc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ACCW-1:0] a;
    logic            o;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  res_t m_st = '0;
  res_t last = '0;
  logic fresh = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [ACCW-1:0] got, input logic [ACCW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic fail(input string nm, input string msg);
    total++;
    bad++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  // Reference: exact product in 64-bit, overflow judged by range of the true sum.
  function automatic res_t model_next(input res_t cur, input logic [AW-1:0] a,
                                      input logic [BW-1:0] b, input logic s,
                                      input logic m, input logic c);
    longint p;
    longint sum;
    longint smax = (longint'(1) <<< (ACCW-1)) - 1;
    longint smin = -(longint'(1) <<< (ACCW-1));
    longint umax = (longint'(1) <<< ACCW) - 1;
    res_t   r;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    r.o = c ? 1'b0 : cur.o;
    if (!m || c) begin
      r.a = p[ACCW-1:0];
    end else if (s) begin
      sum = longint'($signed(cur.a)) + p;
      r.a = sum[ACCW-1:0];
      if (sum > smax) begin
        r.o = 1'b1;
        if (SAT) r.a = smax[ACCW-1:0];
      end else if (sum < smin) begin
        r.o = 1'b1;
        if (SAT) r.a = smin[ACCW-1:0];
      end
    end else begin
      sum = longint'(cur.a) + p;
      r.a = sum[ACCW-1:0];
      if (sum > umax) begin
        r.o = 1'b1;
        if (SAT) r.a = umax[ACCW-1:0];
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_st <= '0;
    end else if (ce && in_valid) begin
      exp_q.push_back(model_next(m_st, ain, bin, is_signed, acc_mode, clr));
      m_st <= model_next(m_st, ain, bin, is_signed, acc_mode, clr);
    end
  end

  always @(posedge clk) fresh <= ce & rst_n;

  // Compare process: every new result against the model, otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      last <= '0;
    end else if (out_valid && fresh) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_result", "out_valid with nothing outstanding");
      end else begin
        chk("model_acc", acc, exp_q[0].a);
        chk1("model_ovf", ovf, exp_q[0].o);
        last <= exp_q[0];
        void'(exp_q.pop_front());
      end
      obs_q.push_back(res_t'({acc, ovf}));
    end else begin
      chk("hold_acc", acc, last.a);
      chk1("hold_ovf", ovf, last.o);
    end
  end

  task automatic op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                    input logic s, input logic m, input logic c);
    ce = 1'b1; in_valid = 1'b1; ain = a; bin = b;
    is_signed = s; acc_mode = m; clr = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    ce = 1'b1; in_valid = 1'b0; clr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic stall(input int n, input logic ev, input logic [ACCW-1:0] ea, input logic eo);
    ce = 1'b0; in_valid = 1'b0;
    for (int i = 0; i <= n; i++) begin
      chk1($sformatf("stall_vld_%0d", i), out_valid, ev);
      chk($sformatf("stall_acc_%0d", i), acc, ea);
      chk1($sformatf("stall_ovf_%0d", i), ovf, eo);
      if (i < n) @(negedge clk);
    end
  endtask

  task automatic take(input string nm, input logic [ACCW-1:0] ea, input logic eo);
    if (obs_q.size() == 0) begin
      fail(nm, "result missing");
    end else begin
      chk({nm, "_acc"}, obs_q[0].a, ea);
      chk1({nm, "_ovf"}, obs_q[0].o, eo);
      void'(obs_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint p_u;
    longint wrap9;
    repeat (3) @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_acc", acc, '0);
    chk1("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    // multiply-only latency: -7 * 6
    op(AW'(-7), BW'(6), 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk1($sformatf("lat_vld_e%0d", k), out_valid, k == PIPE + 1);
      if (k == PIPE + 1) begin
        chk("lat_acc", acc, ACCW'(-42));
        chk1("lat_ovf", ovf, 1'b0);
      end
      @(negedge clk);
    end
    idle(4);
    obs_q.delete();

    // back-to-back accumulate
    op(AW'(3), BW'(4), 1'b1, 1'b1, 1'b1);
    op(AW'(5), BW'(-2), 1'b1, 1'b1, 1'b0);
    op(AW'(10), BW'(10), 1'b1, 1'b1, 1'b0);
    idle(8);
    take("accum1", ACCW'(12), 1'b0);
    take("accum2", ACCW'(2), 1'b0);
    take("accum3", ACCW'(102), 1'b0);

    // same stream with stalls: once mid-pipe, once while a result is presented
    op(AW'(3), BW'(4), 1'b1, 1'b1, 1'b1);
    op(AW'(5), BW'(-2), 1'b1, 1'b1, 1'b0);
    stall(3, 1'b0, ACCW'(102), 1'b0);
    op(AW'(10), BW'(10), 1'b1, 1'b1, 1'b0);
    idle(1);
    stall(2, 1'b1, ACCW'(12), 1'b0);
    idle(8);
    take("stall1", ACCW'(12), 1'b0);
    take("stall2", ACCW'(2), 1'b0);
    take("stall3", ACCW'(102), 1'b0);
    if (obs_q.size() != 0) fail("stall_dup", $sformatf("%0d extra results", obs_q.size()));
    obs_q.delete();

    // signed overflow: 16 x 2^43 reaches 2^47
    for (int i = 0; i < 16; i++) op(27'h400_0000, 18'h2_0000, 1'b1, 1'b1, i == 0);
    op(AW'(2), BW'(3), 1'b1, 1'b1, 1'b1);
    idle(8);
    for (int i = 0; i < 15; i++)
      take($sformatf("ovf_step%0d", i + 1), ACCW'(longint'(i + 1) <<< 43), 1'b0);
    take("ovf_16", SAT ? 48'h7FFF_FFFF_FFFF : 48'h8000_0000_0000, 1'b1);
    take("ovf_clr", ACCW'(6), 1'b0);

    // unsigned vs signed interpretation of the same bits
    op(27'h7FF_FFFF, BW'(2), 1'b0, 1'b0, 1'b0);
    op(27'h7FF_FFFF, BW'(2), 1'b1, 1'b0, 1'b0);
    idle(8);
    take("unsigned_mul", 48'h0000_0FFF_FFFE, 1'b0);
    take("signed_mul", 48'hFFFF_FFFF_FFFE, 1'b0);

    // unsigned accumulate carry-out; then multiply-only keeps ovf, clr drops it
    p_u   = ((longint'(1) <<< 27) - 1) * ((longint'(1) <<< 18) - 1);
    wrap9 = 9 * p_u - (longint'(1) <<< 48);
    for (int i = 0; i < 9; i++) op('1, '1, 1'b0, 1'b1, i == 0);
    op(AW'(2), BW'(3), 1'b1, 1'b0, 1'b0);
    op(AW'(2), BW'(3), 1'b1, 1'b0, 1'b1);
    idle(8);
    for (int i = 0; i < 7; i++) void'(obs_q.pop_front());
    take("uacc_8", ACCW'(8 * p_u), 1'b0);
    take("uacc_9", SAT ? 48'hFFFF_FFFF_FFFF : ACCW'(wrap9), 1'b1);
    take("mul_keeps_ovf", ACCW'(6), 1'b1);
    take("mul_clr_ovf", ACCW'(6), 1'b0);

    // asynchronous reset with work in flight
    op(AW'(1), BW'(1), 1'b1, 1'b1, 1'b1);
    op(AW'(2), BW'(2), 1'b1, 1'b1, 1'b0);
    op(AW'(3), BW'(3), 1'b1, 1'b1, 1'b0);
    idle(1);
    chk1("pre_rst_vld", out_valid, 1'b1);
    chk("pre_rst_acc", acc, ACCW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_vld", out_valid, 1'b0);
    chk("arst_acc", acc, '0);
    chk1("arst_ovf", ovf, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1($sformatf("post_rst_vld_%0d", i), out_valid, 1'b0);
    end
    chk("post_rst_acc", acc, '0);
    chk("outstanding", ACCW'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
